// File: rtl/seq_demux_pkg.sv
// Shared constants and types for the seq_demux 1-to-2 stream demultiplexer.
// Optional per-output transfer counters are enabled with SEQ_DEMUX_CNT_EN.
package seq_demux_pkg;

  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned CNT_W_DEF = 16;

  localparam logic SEL_Y0 = 1'b0;
  localparam logic SEL_Y1 = 1'b1;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/demux_slot.sv
// One-entry output holding slot with valid/ready handshake.
// Optional transfer counter present when SEQ_DEMUX_CNT_EN is defined.
module demux_slot
  import seq_demux_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
`ifdef SEQ_DEMUX_CNT_EN
  , parameter int unsigned CNT_W = CNT_W_DEF
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
`ifdef SEQ_DEMUX_CNT_EN
  , output logic [CNT_W-1:0] out_cnt
`endif
);

  slot_state_e      state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             xfer;

  // State and data registers; reset discards any held beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  // Next state: a load always wins, so drain+load keeps the slot full.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    xfer    = (state_q == SLOT_FULL) && out_ready;
    case (state_q)
      SLOT_EMPTY: if (load) state_d = SLOT_FULL;
      SLOT_FULL: begin
        if (load)           state_d = SLOT_FULL;
        else if (out_ready) state_d = SLOT_EMPTY;
      end
      default: state_d = SLOT_EMPTY;
    endcase
    if (load) data_d = load_data;
  end

  assign out_valid = (state_q == SLOT_FULL);
  assign out_data  = data_q;

`ifdef SEQ_DEMUX_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Completed-transfer counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // Count one per output transfer.
  always_comb begin
    cnt_d = cnt_q;
    if (xfer) cnt_d = cnt_q + CNT_W'(1);
  end

  assign out_cnt = cnt_q;
`else
  logic unused_xfer;
  assign unused_xfer = xfer;
`endif

endmodule

// File: rtl/seq_demux.sv
// Registered 1-to-2 stream demultiplexer with independent per-output slots.
// Optional transfer counters on each output when SEQ_DEMUX_CNT_EN is defined.
module seq_demux
  import seq_demux_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] y0_data,
  output logic [WIDTH-1:0] y1_data,
  output logic             y0_valid,
  output logic             y1_valid,
  input  logic             y0_ready,
  input  logic             y1_ready
`ifdef SEQ_DEMUX_CNT_EN
  , output logic [CNT_W-1:0] y0_cnt
  , output logic [CNT_W-1:0] y1_cnt
`endif
);

  logic load0, load1;
  logic accept;

`ifndef SEQ_DEMUX_CNT_EN
  localparam int unsigned UNUSED_CNT_W = CNT_W;
`endif

  // Ready depends only on the selected slot, never on in_valid.
  always_comb begin
    if (sel == SEL_Y1) in_ready = !y1_valid || y1_ready;
    else               in_ready = !y0_valid || y0_ready;
  end

  assign accept = in_valid && in_ready;
  assign load0  = accept && (sel == SEL_Y0);
  assign load1  = accept && (sel == SEL_Y1);

  demux_slot #(
    .WIDTH (WIDTH)
`ifdef SEQ_DEMUX_CNT_EN
    , .CNT_W (CNT_W)
`endif
  ) u_slot0 (
    .clk       (clk),
    .reset     (reset),
    .load      (load0),
    .load_data (in_data),
    .out_data  (y0_data),
    .out_valid (y0_valid),
    .out_ready (y0_ready)
`ifdef SEQ_DEMUX_CNT_EN
    , .out_cnt (y0_cnt)
`endif
  );

  demux_slot #(
    .WIDTH (WIDTH)
`ifdef SEQ_DEMUX_CNT_EN
    , .CNT_W (CNT_W)
`endif
  ) u_slot1 (
    .clk       (clk),
    .reset     (reset),
    .load      (load1),
    .load_data (in_data),
    .out_data  (y1_data),
    .out_valid (y1_valid),
    .out_ready (y1_ready)
`ifdef SEQ_DEMUX_CNT_EN
    , .out_cnt (y1_cnt)
`endif
  );

endmodule

// File: tb/tb_seq_demux.sv
// Self-checking bench for seq_demux: directed scenarios plus randomized
// traffic compared against a queue-based model of the two output slots.
// Counter checks are active when SEQ_DEMUX_CNT_EN is defined.
module tb_seq_demux;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 4;
  localparam int CNT_MOD = 1 << CNT_W;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] in_data;
  logic             sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] y0_data, y1_data;
  logic             y0_valid, y1_valid;
  logic             y0_ready, y1_ready;
`ifdef SEQ_DEMUX_CNT_EN
  logic [CNT_W-1:0] y0_cnt, y1_cnt;
`endif

  seq_demux #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .sel      (sel),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .y0_data  (y0_data),
    .y1_data  (y1_data),
    .y0_valid (y0_valid),
    .y1_valid (y1_valid),
    .y0_ready (y0_ready),
    .y1_ready (y1_ready)
`ifdef SEQ_DEMUX_CNT_EN
    , .y0_cnt (y0_cnt)
    , .y1_cnt (y1_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: each output is a queue of at most one beat.
  logic [WIDTH-1:0] q0[$];
  logic [WIDTH-1:0] q1[$];
  logic [WIDTH-1:0] last0, last1;
  int               cnt0, cnt1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    last0 = '0;
    last1 = '0;
    cnt0  = 0;
    cnt1  = 0;
  endtask

  // Apply one cycle of inputs, compare outputs to the model, then clock.
  task automatic cycle(input logic r, input logic iv, input logic s,
                       input logic [WIDTH-1:0] d, input logic r0, input logic r1);
    logic exp_rdy;
    logic x0, x1;
    reset    = r;
    in_valid = iv;
    sel      = s;
    in_data  = d;
    y0_ready = r0;
    y1_ready = r1;
    #1;
    exp_rdy = s ? (q1.size() == 0 || r1) : (q0.size() == 0 || r0);
    check("y0_valid", 32'(y0_valid), 32'(q0.size() != 0));
    check("y1_valid", 32'(y1_valid), 32'(q1.size() != 0));
    check("y0_data", 32'(y0_data), 32'((q0.size() != 0) ? q0[0] : last0));
    check("y1_data", 32'(y1_data), 32'((q1.size() != 0) ? q1[0] : last1));
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
`ifdef SEQ_DEMUX_CNT_EN
    check("y0_cnt", 32'(y0_cnt), 32'(cnt0));
    check("y1_cnt", 32'(y1_cnt), 32'(cnt1));
`endif
    if (r) begin
      model_reset();
    end else begin
      x0 = (q0.size() != 0) && r0;
      x1 = (q1.size() != 0) && r1;
      if (x0) begin void'(q0.pop_front()); cnt0 = (cnt0 + 1) % CNT_MOD; end
      if (x1) begin void'(q1.pop_front()); cnt1 = (cnt1 + 1) % CNT_MOD; end
      if (iv && exp_rdy) begin
        if (s) begin q1.push_back(d); last1 = d; end
        else   begin q0.push_back(d); last0 = d; end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; sel = 1'b0; in_data = '0;
    y0_ready = 1'b0; y1_ready = 1'b0;
    model_reset();
    @(negedge clk);

    // Reset for two cycles.
    cycle(1, 0, 0, 8'h00, 0, 0);
    cycle(1, 0, 0, 8'h00, 0, 0);
    reset = 1'b0;
    #1;
    check("rst_y0_valid", 32'(y0_valid), 32'd0);
    check("rst_y1_valid", 32'(y1_valid), 32'd0);
    check("rst_y0_data", 32'(y0_data), 32'd0);
    check("rst_y1_data", 32'(y1_data), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Single beat to y0.
    cycle(0, 1, 0, 8'hA5, 1, 0);
    check("a5_y0_valid", 32'(y0_valid), 32'd1);
    check("a5_y0_data", 32'(y0_data), 32'hA5);
    check("a5_y1_valid", 32'(y1_valid), 32'd0);
    cycle(0, 0, 0, 8'h00, 1, 0);
`ifdef SEQ_DEMUX_CNT_EN
    check("a5_y0_cnt", 32'(y0_cnt), 32'd1);
`endif

    // y1 stalled: only sel=1 traffic is blocked.
    cycle(0, 1, 1, 8'h11, 1, 0);
    sel = 1'b1; in_valid = 1'b1; y1_ready = 1'b0; #1;
    check("stall_in_ready", 32'(in_ready), 32'd0);
    cycle(0, 1, 1, 8'h33, 1, 0);
    check("stall_y1_data", 32'(y1_data), 32'h11);
    sel = 1'b0; #1;
    check("other_in_ready", 32'(in_ready), 32'd1);
    cycle(0, 1, 0, 8'h22, 1, 0);
    check("other_y0_data", 32'(y0_data), 32'h22);
    check("held_y1_data", 32'(y1_data), 32'h11);

    // Alternating back-to-back stream from a clean state.
    cycle(1, 0, 0, 8'h00, 1, 1);
    for (int i = 1; i <= 4; i++) begin
      cycle(0, 1, ((i % 2) == 0), 8'(i), 1, 1);
      if ((i % 2) == 1) check("alt_y0_data", 32'(y0_data), 32'(i));
      else              check("alt_y1_data", 32'(y1_data), 32'(i));
    end
    cycle(0, 0, 0, 8'h00, 1, 1);
`ifdef SEQ_DEMUX_CNT_EN
    check("alt_y0_cnt", 32'(y0_cnt), 32'd2);
    check("alt_y1_cnt", 32'(y1_cnt), 32'd2);
`endif

    // Drain and reload of y0 in the same cycle.
    cycle(0, 1, 0, 8'h10, 0, 1);
    cycle(0, 1, 0, 8'h20, 1, 1);
    check("reload_y0_valid", 32'(y0_valid), 32'd1);
    check("reload_y0_data", 32'(y0_data), 32'h20);

    // Reset wins over a simultaneous drain of y1.
    cycle(0, 1, 1, 8'h55, 1, 0);
    cycle(1, 0, 0, 8'h00, 1, 1);
    check("rstdrain_y1_valid", 32'(y1_valid), 32'd0);
`ifdef SEQ_DEMUX_CNT_EN
    check("rstdrain_y1_cnt", 32'(y1_cnt), 32'd0);
`endif

    // Sixteen y0 transfers wrap the 4-bit counter.
    for (int i = 0; i < 16; i++) cycle(0, 1, 0, 8'(8'h40 + i), 1, 1);
`ifdef SEQ_DEMUX_CNT_EN
    check("wrap_y0_cnt15", 32'(y0_cnt), 32'd15);
`endif
    cycle(0, 0, 0, 8'h00, 1, 1);
`ifdef SEQ_DEMUX_CNT_EN
    check("wrap_y0_cnt0", 32'(y0_cnt), 32'd0);
`endif

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 99) == 0),
            1'($urandom_range(0, 3) != 0),
            1'($urandom),
            8'($urandom),
            1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 2) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seq_demux.md
# seq_demux

Registered 1-to-2 stream demultiplexer: the inverse of the 2:1 mux, routing one input stream to one of two output streams chosen by `sel`. Each output has its own one-entry holding slot with a valid/ready handshake, so a stalled output never blocks traffic bound for the other. The block sits wherever one producer feeds two consumers, and is verified with a self-checking testbench in the same style as the existing mux benches.

## Interface
Parameters:
- `WIDTH`, 8, data width in bits.
- `CNT_W`, 16, width of the per-output transfer counters. Used only when `SEQ_DEMUX_CNT_EN` is defined.

Ports:
- `clk`  input  1  single clock; all state changes on the rising edge.
- `reset`  input  1  synchronous reset, active-high.
- `in_data`  input  WIDTH  input payload.
- `sel`  input  1  destination select: 0 routes to `y0`, 1 routes to `y1`. Sampled only with `in_valid`.
- `in_valid`  input  1  input beat valid.
- `in_ready`  output  1  block can accept the beat for the current `sel`.
- `y0_data`, `y1_data`  output  WIDTH  output payloads.
- `y0_valid`, `y1_valid`  output  1  output slot holds a beat.
- `y0_ready`, `y1_ready`  input  1  consumer accepts the beat.
- `y0_cnt`, `y1_cnt`  output  CNT_W  completed output transfers. Present only when `SEQ_DEMUX_CNT_EN` is defined.

## Operation
- Each output slot has two states, EMPTY and FULL. `yN_valid` is 1 exactly when slot N is FULL.
- `in_ready = !yS_valid | yS_ready`, where S = `sel`. This is combinational from `sel` and the selected output's valid/ready; there is no path from `in_valid`.
- Input accept = `in_valid & in_ready`. On accept, slot S loads `in_data` and becomes FULL.
- Output transfer on N = `yN_valid & yN_ready`. On a transfer, slot N becomes EMPTY unless it is reloaded in the same cycle.
- Drain and load of the same slot in the same cycle: the new data is loaded and `yN_valid` stays 1. There is no bubble.
- The two slots are independent. A load into one slot can coincide with a drain of the other.
- While `yN_valid` is 1, `yN_data` is stable until the transfer completes.
- While a slot is EMPTY, its `yN_data` holds the last value loaded, or 0 after reset.
- `in_data` and `sel` are ignored when `in_valid` is 0.
- Reset values:
  - `y0_valid` = `y1_valid` = 0.
  - `y0_data` = `y1_data` = 0.
  - Counters = 0 (when enabled).
  - `in_ready` therefore reads 1 after reset.
- Reset mid-operation: data in the slots is discarded with no transfer. Reset has priority over a simultaneous load or drain.

## Timing
- Latency: 1 cycle. A beat accepted at edge k appears on `yS_valid`/`yS_data` after edge k.
- Throughput: 1 beat per cycle per output, provided that consumer holds ready high.
- A FULL slot whose ready is low stalls only inputs that select it. `in_ready` drops for that `sel` value only.
- No combinational path from `in_data` to any output.

## Configuration
- `SEQ_DEMUX_CNT_EN` defined:
  - `y0_cnt`/`y1_cnt` ports exist.
  - Each counter increments by 1 per transfer on its output.
  - Counters wrap from 2^CNT_W−1 to 0.
  - A transfer in the reset cycle is not counted.
- `SEQ_DEMUX_CNT_EN` undefined: the counter ports and logic are absent, and all other behaviour is identical.

## Structure
- Shared package `seq_demux_pkg`: `SEL_Y0` = 1'b0, `SEL_Y1` = 1'b1, default `WIDTH` and `CNT_W` constants.
- Sub-module `demux_slot`: a one-entry buffer with load, data, valid, ready, and an optional counter under the same macro. It is instantiated twice, and the load enable is `in_valid & in_ready & (sel == N)`.

## Test plan
- Reset with `reset`=1 for 2 cycles → both valids 0, both data 0, `in_ready`=1, counters 0.
- `sel`=0, `in_data`=8'hA5, `in_valid`=1 for one cycle, `y0_ready`=1 → `y0_valid`=1 with `y0_data`=8'hA5 one cycle later; `y1_valid` stays 0; `y0_cnt`=1.
- `y1_ready`=0, send 8'h11 to `y1` and then hold `sel`=1 → `in_ready`=0 and `y1_data` stays 8'h11. Switch to `sel`=0 with 8'h22 → accepted, and `y0_data`=8'h22 next cycle.
- Both readies 1, stream alternating `sel` 0/1/0/1 with data 1..4 on back-to-back cycles → no stall, `y0` sees 1 and 3, `y1` sees 2 and 4, both counters 2.
- Slot `y0` FULL with 8'h10, `y0_ready`=1 while loading 8'h20 in the same cycle → `y0_valid` stays 1 and `y0_data`=8'h20 next cycle.
- With `y1` FULL, assert `reset` together with `y1_ready`=1 → `y1_valid`=0 next cycle and `y1_cnt`=0. With CNT_W=4, 16 transfers wrap `y0_cnt` back to 0.
